// File: rtl/music_note_sequencer.sv
// Song playback engine: walks the note ROM one slot per TICK_DIV cycles and drives note/gate/strobe to the synth.
// Optional ARTIC_GAP_EN macro silences the gate for the last GAP_CYC cycles of every slot.
module music_note_sequencer #(
   parameter int          ADDR_W    = 9,
   parameter int          TICK_DIV  = 6000000,
   parameter logic [7:0]  REST_CODE = 8'd255,
   parameter logic [7:0]  END_CODE  = 8'd1,
   parameter int          GAP_CYC   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_note,
   output logic [7:0]        note_out,
   output logic              gate,
   output logic              note_strobe,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(TICK_DIV);
`ifdef ARTIC_GAP_EN
   localparam bit GAP_ON = 1'b1;
`else
   localparam bit GAP_ON = 1'b0;
`endif
   // PLAY runs TICK_DIV-2 cycles; FETCH and LATCH make up the rest of the slot.
   localparam logic [CNT_W-1:0] SLOT_LOAD = CNT_W'(TICK_DIV - 3);
   localparam logic [CNT_W-1:0] GAP_AT    = CNT_W'(GAP_CYC - 2);

   typedef enum logic [2:0] {IDLE, FETCH, LATCH, PLAY, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             slot_end;
   logic             end_evt;

   always_comb begin
      slot_end = (state == PLAY) && (cnt == '0);
      // Running off the top of the ROM is treated exactly like reading the end marker.
      end_evt  = ((state == LATCH) && (rom_note == END_CODE)) || (slot_end && (&rom_addr));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rom_addr    <= '0;
         note_out    <= REST_CODE;
         gate        <= 1'b0;
         note_strobe <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cnt         <= '0;
      end else begin
         note_strobe <= 1'b0;
         if (GAP_ON && (state == PLAY) && (cnt == GAP_AT))
            gate <= 1'b0;

         if (stop) begin
            state    <= IDLE;
            rom_addr <= '0;
            note_out <= REST_CODE;
            gate     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
         end else if (end_evt) begin
            if (loop_en) begin
               rom_addr <= '0;
               state    <= FETCH;
            end else begin
               state    <= DONE;
               busy     <= 1'b0;
               done     <= 1'b1;
               gate     <= 1'b0;
               note_out <= REST_CODE;
            end
         end else begin
            unique case (state)
               IDLE: begin
                  rom_addr <= '0;
                  if (start) begin
                     state <= FETCH;
                     busy  <= 1'b1;
                  end
               end
               FETCH: state <= LATCH;
               LATCH: begin
                  note_out    <= rom_note;
                  gate        <= (rom_note != REST_CODE);
                  note_strobe <= 1'b1;
                  cnt         <= SLOT_LOAD;
                  state       <= PLAY;
               end
               PLAY: begin
                  if (cnt == '0) begin
                     rom_addr <= rom_addr + 1'b1;
                     state    <= FETCH;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               DONE: begin
                  if (start) begin
                     rom_addr <= '0;
                     state    <= FETCH;
                     busy     <= 1'b1;
                     done     <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_music_note_sequencer.sv
// Bench for music_note_sequencer: spec song table, stop/reset/wrap corner cases, random songs vs a song-walk model.
module tb_music_note_sequencer;

   localparam int TD = 8;
`ifdef ARTIC_GAP_EN
   localparam int GATE_HI = 4;
`else
   localparam int GATE_HI = 8;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, stop = 1'b0, loop_en = 1'b0;
   logic [8:0] rom_addr;
   logic [7:0] rom_note = 8'd1;
   logic [7:0] note_out;
   logic       gate, note_strobe, busy, done;

   logic       start2 = 1'b0, stop2 = 1'b0, loop2 = 1'b0;
   logic [2:0] rom_addr2;
   logic [7:0] rom_note2 = 8'd0;
   logic [7:0] note_out2;
   logic       gate2, note_strobe2, busy2, done2;

   always #5 clk = ~clk;

   music_note_sequencer #(.ADDR_W(9), .TICK_DIV(TD)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
      .rom_addr(rom_addr), .rom_note(rom_note), .note_out(note_out), .gate(gate),
      .note_strobe(note_strobe), .busy(busy), .done(done));

   music_note_sequencer #(.ADDR_W(3), .TICK_DIV(TD)) dut_w (
      .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop2), .loop_en(loop2),
      .rom_addr(rom_addr2), .rom_note(rom_note2), .note_out(note_out2), .gate(gate2),
      .note_strobe(note_strobe2), .busy(busy2), .done(done2));

   // Registered ROM models
   logic [7:0] mem [0:511];
   always @(posedge clk) rom_note  <= mem[rom_addr];
   always @(posedge clk) rom_note2 <= 8'd60;

   typedef struct {
      int         t;
      logic [7:0] note;
      logic       gate;
      int         addr;
   } ev_t;

   ev_t obs[$];
   ev_t obs2[$];
   ev_t expq[$];
   ev_t e1, e2;
   bit  exp_done;
   int  ncyc = 0;

   always @(negedge clk) begin
      ncyc++;
      if (note_strobe === 1'b1) begin
         e1.t = ncyc; e1.note = note_out; e1.gate = gate; e1.addr = int'(rom_addr);
         obs.push_back(e1);
      end
      if (note_strobe2 === 1'b1) begin
         e2.t = ncyc; e2.note = note_out2; e2.gate = gate2; e2.addr = int'(rom_addr2);
         obs2.push_back(e2);
      end
   end

   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Walks the song from address 0, timing each slot, until the window closes or the song ends.
   task automatic model(input bit lp, input int win);
      int  addr = 0;
      int  t = 3;
      int  guard = 0;
      ev_t ev;
      expq.delete();
      exp_done = 1'b0;
      while (t <= win && guard < 5000) begin
         guard++;
         if (mem[addr] == 8'd1) begin
            if (lp) begin addr = 0; t += 2; end
            else begin exp_done = 1'b1; break; end
         end else begin
            ev.t = t; ev.note = mem[addr]; ev.gate = (mem[addr] != 8'd255); ev.addr = addr;
            expq.push_back(ev);
            t += TD;
            if (addr == 511) begin
               if (lp) addr = 0;
               else begin exp_done = 1'b1; break; end
            end else addr++;
         end
      end
   endtask

   task automatic pulse_stop();
      @(posedge clk); #1 stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
   endtask

   // Starts playback, pokes start while busy (must be ignored), then compares observed strobes to expq.
   task automatic play(input bit lp, input int win, output int t0);
      @(posedge clk); #1 loop_en = lp; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      t0 = ncyc;
      obs.delete();
      for (int k = 1; k <= win; k++) begin
         @(negedge clk);
         start = (k == 5 || k == 9);
      end
      start = 1'b0;
      #1;
      chk("strobe_count", obs.size(), expq.size());
      for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
         chk("strobe_time", obs[i].t - t0, expq[i].t);
         chk("strobe_note", obs[i].note, expq[i].note);
         chk("strobe_gate", obs[i].gate, expq[i].gate);
         chk("strobe_addr", obs[i].addr, expq[i].addr);
      end
      if (lp) begin
         chk("loop_busy", busy, 1);
         chk("loop_done", done, 0);
      end else begin
         chk("end_done", done, 1);
         chk("end_busy", busy, 0);
         chk("end_gate", gate, 0);
         chk("end_note", note_out, 255);
      end
   endtask

   typedef struct {
      bit         lp;
      int         idx;
      int         t;
      logic [7:0] note;
      logic       gate;
      int         addr;
   } vec_t;

   vec_t vt[10];

   task automatic load_song();
      for (int a = 0; a < 512; a++) mem[a] = 8'd1;
      mem[0] = 8'd66; mem[1] = 8'd66; mem[2] = 8'd255; mem[3] = 8'd71;
   endtask

   initial begin
      int t0, win, hi, cnt_before;
      bit seen;

      vt[0] = '{0, 0,  3, 8'd66,  1'b1, 0};
      vt[1] = '{0, 1, 11, 8'd66,  1'b1, 1};
      vt[2] = '{0, 2, 19, 8'd255, 1'b0, 2};
      vt[3] = '{0, 3, 27, 8'd71,  1'b1, 3};
      vt[4] = '{1, 0,  3, 8'd66,  1'b1, 0};
      vt[5] = '{1, 1, 11, 8'd66,  1'b1, 1};
      vt[6] = '{1, 2, 19, 8'd255, 1'b0, 2};
      vt[7] = '{1, 3, 27, 8'd71,  1'b1, 3};
      vt[8] = '{1, 4, 37, 8'd66,  1'b1, 0};
      vt[9] = '{1, 5, 45, 8'd66,  1'b1, 1};

      load_song();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_note", note_out, 255);
      chk("rst_gate", gate, 0);
      chk("rst_strobe", note_strobe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", rom_addr, 0);
      @(negedge clk); rst_n = 1'b1;

      // Spec song, once to the end, once looping
      for (int lp = 0; lp < 2; lp++) begin
         if (lp == 0) begin model(0, 10000); win = 39; end
         else begin win = 48; model(1, win); end
         play(lp[0], win, t0);
         for (int i = 0; i < 10; i++) begin
            if (vt[i].lp == lp[0]) begin
               if (vt[i].idx < obs.size()) begin
                  chk("tbl_time", obs[vt[i].idx].t - t0, vt[i].t);
                  chk("tbl_note", obs[vt[i].idx].note, vt[i].note);
                  chk("tbl_gate", obs[vt[i].idx].gate, vt[i].gate);
                  chk("tbl_addr", obs[vt[i].idx].addr, vt[i].addr);
               end else begin
                  chk("tbl_missing", obs.size(), vt[i].idx + 1);
               end
            end
         end
         chk("tbl_count", obs.size(), lp ? 6 : 4);
         if (busy) pulse_stop();
      end

      // Gate across the first 66 slot
      @(posedge clk); #1 loop_en = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         seen = (note_strobe === 1'b1);
      end
      chk("gate_strobe_seen", seen, 1);
      hi = int'(gate);
      repeat (7) begin @(negedge clk); hi += int'(gate); end
      chk("gate_hi_cycles", hi, GATE_HI);
      pulse_stop();

      // Stop in the middle of slot 2
      @(posedge clk); #1 loop_en = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      obs.delete();
      for (int k = 0; k < 40 && obs.size() < 2; k++) @(negedge clk);
      chk("stop_reached_slot2", obs.size(), 2);
      repeat (2) @(negedge clk);
      @(posedge clk); #1 stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      chk("stop_busy", busy, 0);
      chk("stop_gate", gate, 0);
      chk("stop_note", note_out, 255);
      chk("stop_addr", rom_addr, 0);
      chk("stop_done", done, 0);
      chk("stop_strobe", note_strobe, 0);
      cnt_before = obs.size();
      repeat (20) @(negedge clk);
      #1 chk("stop_quiet", obs.size(), cnt_before);
      model(0, 10000);
      play(0, 39, t0);

      // Asynchronous reset between edges
      @(posedge clk); #1 loop_en = 1'b1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      obs.delete();
      for (int k = 0; k < 20 && obs.size() < 1; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_note", note_out, 255);
      chk("arst_gate", gate, 0);
      chk("arst_strobe", note_strobe, 0);
      chk("arst_busy", busy, 0);
      chk("arst_addr", rom_addr, 0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      obs.delete();
      repeat (20) @(negedge clk);
      #1;
      chk("arst_quiet", obs.size(), 0);
      chk("arst_idle", busy, 0);

      // Address wrap on the 3-bit instance, finish then loop
      @(posedge clk); #1 loop2 = 1'b0; start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0; t0 = ncyc;
      obs2.delete();
      repeat (8 * TD + 14) @(negedge clk);
      #1;
      chk("wrap_count", obs2.size(), 8);
      for (int i = 0; i < obs2.size() && i < 8; i++) begin
         chk("wrap_addr", obs2[i].addr, i);
         chk("wrap_time", obs2[i].t - t0, 3 + TD * i);
         chk("wrap_note", obs2[i].note, 60);
      end
      chk("wrap_done", done2, 1);
      chk("wrap_gate", gate2, 0);
      @(posedge clk); #1 loop2 = 1'b1; start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0; t0 = ncyc;
      obs2.delete();
      repeat (3 + TD * 8 + 2) @(negedge clk);
      #1;
      chk("wraploop_count", obs2.size(), 9);
      if (obs2.size() >= 9) begin
         chk("wraploop_addr", obs2[8].addr, 0);
         chk("wraploop_time", obs2[8].t - t0, 3 + TD * 8);
      end
      chk("wraploop_done", done2, 0);
      @(posedge clk); #1 stop2 = 1'b1;
      @(posedge clk); #1 stop2 = 1'b0;

      // Random songs: repeats, rests, end marker position, loop/no loop
      for (int it = 0; it < 12; it++) begin
         int L, r;
         bit lp;
         for (int a = 0; a < 512; a++) mem[a] = 8'd1;
         L = $urandom_range(2, 8);
         for (int a = 0; a < L; a++) begin
            r = $urandom_range(0, 9);
            if (r == 0) mem[a] = 8'd255;
            else if (r == 1 && a > 0) mem[a] = mem[a-1];
            else mem[a] = 8'($urandom_range(2, 254));
         end
         lp = 1'($urandom_range(0, 1));
         if (lp) begin
            win = $urandom_range(30, 100);
            model(1, win);
         end else begin
            model(0, 10000);
            win = expq[expq.size()-1].t + TD + 4;
         end
         play(lp, win, t0);
         if (busy) pulse_stop();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
